// File: rtl/mod_barrett_pkg.sv
// Shared constants and FSM state type for the Barrett parameter generator and multiplier.
package mod_barrett_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned K_W    = 7;
  localparam int unsigned U_W    = 2 * DATA_W;
  // Bit counter must hold 2*K up to 128.
  localparam int unsigned CNT_W  = K_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StDiv,
    StDone
  } state_e;

endpackage

// File: rtl/lzc_64b.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module lzc_64b #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_lzc
);

  // Scan LSB to MSB so the highest set bit writes last.
  always_comb begin
    o_lzc = CNT_W'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i_data[i]) begin
        o_lzc = CNT_W'(int'(WIDTH) - 1 - i);
      end
    end
  end

endmodule

// File: rtl/mod_barrett_param_gen_64b.sv
// Barrett constant generator: K = bit-length of the modulus, U = floor(2^(2K) / modulus),
// computed by a one-bit-per-cycle restoring divider.
module mod_barrett_param_gen_64b
  import mod_barrett_pkg::*;
(
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iClr,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iMod,
  output logic              oValid,
  input  logic              iReady,
  output logic [K_W-1:0]    oK,
  output logic [U_W-1:0]    oU,
  output logic              oErr
);

  state_e             r_state;
  state_e             w_state_d;
  logic [DATA_W-1:0]  r_m;
  logic [DATA_W:0]    r_r;
  logic [U_W-1:0]     r_q;
  logic [CNT_W-1:0]   r_cnt;
  logic [K_W-1:0]     r_k;
  logic               r_valid;
  logic               r_err;

  logic [K_W-1:0]     w_lzc;
  logic [K_W-1:0]     w_k;
  logic               w_m_zero;
  logic               w_d;
  logic [DATA_W:0]    w_rp;
  logic               w_ge;
  logic               w_accept;

  lzc_64b #(
    .WIDTH (DATA_W),
    .CNT_W (K_W)
  ) u_lzc (
    .i_data (r_m),
    .o_lzc  (w_lzc)
  );

  assign w_k      = K_W'(DATA_W) - w_lzc;
  assign w_m_zero = (r_m == '0);
  assign oReady   = (r_state == StIdle);
  assign w_accept = iValid && oReady && !iClr;

  // Dividend 2^(2K) has a single one at its MSB, consumed on the first step.
  assign w_d  = (r_cnt == {r_k, 1'b0});
  // R < m always, so R fits DATA_W bits and the shifted value fits DATA_W+1.
  assign w_rp = {r_r[DATA_W-1:0], w_d};
  assign w_ge = (w_rp >= {1'b0, r_m});

  always_comb begin
    w_state_d = r_state;
    if (iClr) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: if (w_accept) w_state_d = StNorm;
        StNorm: w_state_d = w_m_zero ? StDone : StDiv;
        StDiv:  if (r_cnt == '0) w_state_d = StDone;
        StDone: if (iReady) w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_m     <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_k     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (iClr) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) r_m <= iMod;
        end
        StNorm: begin
          if (w_m_zero) begin
            r_k     <= '0;
            r_q     <= '1;
            r_err   <= 1'b1;
            r_valid <= 1'b1;
          end else begin
            r_k   <= w_k;
            r_r   <= '0;
            r_q   <= '0;
            r_err <= 1'b0;
            r_cnt <= {w_k, 1'b0};
          end
        end
        StDiv: begin
          r_r   <= w_ge ? (w_rp - {1'b0, r_m}) : w_rp;
          r_q   <= {r_q[U_W-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_valid <= 1'b1;
        end
        StDone: begin
          if (iReady) r_valid <= 1'b0;
        end
        default: begin
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign oValid = r_valid;
  assign oK     = r_k;
  assign oU     = r_q;
  assign oErr   = r_err;

endmodule

// File: tb/tb_mod_barrett_param_gen_64b.sv
// Directed self-checking bench for the Barrett parameter generator.
module tb_mod_barrett_param_gen_64b;

  logic          iClk;
  logic          iRstN;
  logic          iClr;
  logic          iValid;
  logic          oReady;
  logic [63:0]   iMod;
  logic          oValid;
  logic          iReady;
  logic [6:0]    oK;
  logic [127:0]  oU;
  logic          oErr;

  int n_total;
  int n_pass;

  mod_barrett_param_gen_64b u_dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iClr   (iClr),
    .iValid (iValid),
    .oReady (oReady),
    .iMod   (iMod),
    .oValid (oValid),
    .iReady (iReady),
    .oK     (oK),
    .oU     (oU),
    .oErr   (oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a modulus and return after the accepting edge (sampled at the following negedge).
  task automatic accept(input logic [63:0] m, input string tag);
    int tmo;
    tmo = 0;
    @(negedge iClk);
    while (!oReady && tmo < 300) begin
      @(negedge iClk);
      tmo++;
    end
    check({tag, "_ready_to"}, 128'(tmo < 300), 128'(1));
    iValid = 1'b1;
    iMod   = m;
    @(negedge iClk);
    iValid = 1'b0;
    iMod   = 64'hDEAD_BEEF_0BAD_F00D;
  endtask

  // Counts accept edge as cycle 1; returns latency until oValid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!oValid && lat < 300) begin
      @(negedge iClk);
      lat++;
    end
  endtask

  task automatic run_job(input logic [63:0] m, input logic [6:0] exp_k,
                         input logic [127:0] exp_u, input logic exp_err,
                         input int exp_lat, input int hold, input string tag);
    int lat;
    bit stable;
    accept(m, tag);
    wait_valid(lat);
    check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    check({tag, "_k"}, 128'(oK), 128'(exp_k));
    check({tag, "_u"}, oU, exp_u);
    check({tag, "_err"}, 128'(oErr), 128'(exp_err));
    check({tag, "_busy"}, 128'(oReady), 128'(0));
    if (hold > 0) begin
      stable = 1'b1;
      iValid = 1'b1;
      iMod   = 64'd3;
      for (int i = 0; i < hold; i++) begin
        @(negedge iClk);
        if (!oValid || oReady || oK !== exp_k || oU !== exp_u || oErr !== exp_err) stable = 1'b0;
      end
      iValid = 1'b0;
      check({tag, "_hold_stable"}, 128'(stable), 128'(1));
    end
    iReady = 1'b1;
    @(negedge iClk);
    iReady = 1'b0;
    check({tag, "_drop_valid"}, 128'(oValid), 128'(0));
    check({tag, "_ready_after"}, 128'(oReady), 128'(1));
    check({tag, "_u_kept"}, oU, exp_u);
  endtask

  initial begin
    int lat;
    bit never;
    n_total = 0;
    n_pass  = 0;
    iRstN   = 1'b0;
    iClr    = 1'b0;
    iValid  = 1'b0;
    iReady  = 1'b0;
    iMod    = '0;
    repeat (3) @(negedge iClk);
    iRstN = 1'b1;
    @(negedge iClk);
    check("rst_valid", 128'(oValid), 128'(0));
    check("rst_ready", 128'(oReady), 128'(1));
    check("rst_k", 128'(oK), 128'(0));
    check("rst_u", oU, 128'(0));
    check("rst_err", 128'(oErr), 128'(0));

    // Reset in the middle of a division.
    accept(64'd7681, "rst_mid");
    repeat (9) @(negedge iClk);
    iRstN = 1'b0;
    #1;
    check("rst_mid_valid", 128'(oValid), 128'(0));
    check("rst_mid_k", 128'(oK), 128'(0));
    @(negedge iClk);
    iRstN = 1'b1;
    @(negedge iClk);
    check("rst_mid_ready", 128'(oReady), 128'(1));

    run_job(64'd7681, 7'd13, 128'd8736, 1'b0, 29, 0, "m7681");
    run_job(64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 128'h1_0000_0000_0000_0001, 1'b0, 131, 0, "mmax");
    run_job(64'd1, 7'd1, 128'd4, 1'b0, 5, 0, "m1");
    run_job(64'd8, 7'd4, 128'd32, 1'b0, 11, 20, "m8_bp");
    run_job(64'h8000_0000_0000_0000, 7'd64, 128'h2_0000_0000_0000_0000, 1'b0, 131, 0, "m2p63");
    run_job(64'd0, 7'd0, {128{1'b1}}, 1'b1, 2, 0, "m0");
    run_job(64'd3, 7'd2, 128'd5, 1'b0, 7, 0, "m3");

    // Abort during the divide: no result may appear.
    accept(64'd7681, "clr_div");
    repeat (4) @(negedge iClk);
    iClr = 1'b1;
    @(negedge iClk);
    iClr = 1'b0;
    check("clr_div_valid", 128'(oValid), 128'(0));
    check("clr_div_ready", 128'(oReady), 128'(1));
    never = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge iClk);
      if (oValid) never = 1'b0;
    end
    check("clr_div_no_result", 128'(never), 128'(1));

    // Abort in DONE together with iReady, on an error result.
    accept(64'd0, "clr_done");
    wait_valid(lat);
    check("clr_done_lat", 128'(lat), 128'(2));
    iClr   = 1'b1;
    iReady = 1'b1;
    @(negedge iClk);
    iClr   = 1'b0;
    iReady = 1'b0;
    check("clr_done_valid", 128'(oValid), 128'(0));
    check("clr_done_err", 128'(oErr), 128'(0));
    check("clr_done_ready", 128'(oReady), 128'(1));

    // iClr with iValid in IDLE must not accept.
    iClr   = 1'b1;
    iValid = 1'b1;
    iMod   = 64'd5;
    @(negedge iClk);
    iClr   = 1'b0;
    iValid = 1'b0;
    check("clr_idle_not_acc", 128'(oReady), 128'(1));
    @(negedge iClk);
    check("clr_idle_still", 128'(oReady), 128'(1));

    run_job(64'd7681, 7'd13, 128'd8736, 1'b0, 29, 0, "after_clr");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
